// File: rtl/riscv_imem_resp.sv
// Instruction-memory responder for the fetch stage.
// A word-addressed instruction store is read after a programmable number of
// wait states. A busy/ready handshake paces requests, a flush drops a fetch that
// is still waiting, and misaligned or out-of-range addresses return a NOP with
// the error flag set. A loader port fills the store before execution.

module riscv_imem_resp #(
    parameter int          PC_SIZE     = 32,
    parameter int          MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000,
    parameter int          WAIT_STATES = 1,
    localparam int         AW          = $clog2(MEM_DEPTH)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               ird,
    input  logic [PC_SIZE-1:0] iaddr_i,
    input  logic               flush_i,
    output logic               irdy_o,
    output logic               ivalid_o,
    output logic [31:0]        idata_o,
    output logic [PC_SIZE-1:0] iaddr_o,
    output logic               ierr_o,
    input  logic               load_we_i,
    input  logic [AW-1:0]      load_addr_i,
    input  logic [31:0]        load_data_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [31:0]        NOP_INSN = 32'h0000_0013;
    localparam logic [3:0]         WS_C     = 4'(WAIT_STATES);
    localparam logic [PC_SIZE-1:0] BASE_S   = PC_SIZE'(BASE_ADDR);
    localparam logic [PC_SIZE:0]   DEPTH_S  = (PC_SIZE+1)'(MEM_DEPTH);

    // Instruction store; deliberately not reset.
    logic [31:0] mem_r [MEM_DEPTH];

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_nxt_s;
    logic [PC_SIZE-1:0] req_addr_r;
    logic               req_err_r;
    logic [AW-1:0]      req_idx_r;
    logic               ivalid_r;
    logic [31:0]        idata_r;
    logic [PC_SIZE-1:0] iaddr_r;
    logic               ierr_r;

    logic               irdy_s;
    logic               accept_s;
    logic               finish_s;
    logic [PC_SIZE-1:0] off_s;
    logic [PC_SIZE-1:0] word_s;
    logic               below_s;
    logic               beyond_s;
    logic               misalign_s;
    logic               req_err_s;

    assign irdy_s   = (state_r == IDLE) || (state_r == RESP);
    assign accept_s = ird && irdy_s;
    // Last BUSY edge that actually produces a response (not killed by flush).
    assign finish_s = (state_r == BUSY) && !flush_i && (cnt_r == 4'd0);

    // Address qualification at accept time: alignment and store bounds,
    // evaluated without wrap-around so addresses below the base are caught.
    always_comb begin
        off_s      = iaddr_i - BASE_S;
        word_s     = off_s >> 2;
        below_s    = (iaddr_i < BASE_S);
        beyond_s   = ({1'b0, word_s} >= DEPTH_S);
        misalign_s = (iaddr_i[1:0] != 2'b00);
        req_err_s  = misalign_s || below_s || beyond_s;
    end

    // Next state and wait-counter update.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = BUSY;
                    cnt_nxt_s   = WS_C;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r != 4'd0) begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            RESP: begin
                if (accept_s) begin
                    state_nxt_s = BUSY;
                    cnt_nxt_s   = WS_C;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Control state: FSM, wait counter and response strobe.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            ivalid_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            ivalid_r <= (state_nxt_s == RESP);
        end
    end

    // Request capture on accept and response registers on completion.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            req_addr_r <= '0;
            req_err_r  <= 1'b0;
            req_idx_r  <= '0;
            idata_r    <= 32'h0000_0000;
            iaddr_r    <= '0;
            ierr_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                req_addr_r <= iaddr_i;
                req_err_r  <= req_err_s;
                req_idx_r  <= word_s[AW-1:0];
            end
            if (finish_s) begin
                idata_r <= req_err_r ? NOP_INSN : mem_r[req_idx_r];
                iaddr_r <= req_addr_r;
                ierr_r  <= req_err_r;
            end
        end
    end

    // Loader write port; the response read above sees the pre-write value.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem_r[load_addr_i] <= load_data_i;
        end
    end

    assign irdy_o   = irdy_s;
    assign ivalid_o = ivalid_r;
    assign idata_o  = idata_r;
    assign iaddr_o  = iaddr_r;
    assign ierr_o   = ierr_r;

endmodule
